spi_master_multi: RTL and testbench

Parametrised SPI controller for the delay core, replacing the fixed-mode, fixed-length controller used for the codec and SRAM links. It runs all four SPI modes (CPOL/CPHA) and a programmable SCK divider. Each transfer has a run-time bit length and drives one of several chip selects. SCK is a registered output, not a gated clock. A start/busy/done handshake lets the delay sequencer issue back-to-back transactions to different devices over one bus.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sck_gen.sv | 47 ++++
 rtl/spi_master_multi.sv | 157 +++++++++++++++
 tb/tb_spi_master_multi.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the multi-mode SPI controller: FSM state encoding and
// the CPOL/CPHA mode pair.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        DONE
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = 2'b00;
    localparam spi_mode_t SPI_MODE1 = 2'b01;
    localparam spi_mode_t SPI_MODE2 = 2'b10;
    localparam spi_mode_t SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK timing base: ticks once every clk_div+1 cycles while enabled and keeps
// count of the SCK edges produced in the shift phase.
module spi_sck_gen #(
    parameter int DIV_WIDTH = 8,
    parameter int NBW       = 6
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_load,
    input  logic [DIV_WIDTH-1:0] i_clk_div,
    input  logic [NBW-1:0]       i_nbits,
    input  logic                 i_en,
    input  logic                 i_shift,
    output logic                 o_tick,
    output logic                 o_leading,
    output logic                 o_last_edge
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [NBW:0]         r_edge;
    logic [NBW:0]         w_last_idx;

    // r_edge counts edges already emitted, so edge number r_edge+1 is next.
    assign w_last_idx  = {i_nbits, 1'b0} - {{NBW{1'b0}}, 1'b1};
    assign o_tick      = i_en && (r_cnt == '0);
    assign o_leading   = ~r_edge[0];
    assign o_last_edge = (r_edge == w_last_idx);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cnt  <= '0;
            r_div  <= '0;
            r_edge <= '0;
        end else if (i_load) begin
            r_cnt  <= i_clk_div;
            r_div  <= i_clk_div;
            r_edge <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? r_div : r_cnt - 1'b1;
            if (o_tick && i_shift) begin
                r_edge <= r_edge + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master supporting all four CPOL/CPHA modes, run-time transfer length,
// programmable SCK half-period and one of NCS chip selects per transfer.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NCS        = 2,
    parameter int DIV_WIDTH  = 8,
    localparam int CSW       = (NCS > 1) ? $clog2(NCS) : 1,
    localparam int NBW       = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [CSW-1:0]        cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [NBW-1:0]        nbits,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sck,
    output logic                  sdo,
    input  logic                  sdi,
    output logic [NCS-1:0]        cs_n
);

    localparam logic [NBW-1:0] MAX_NB = NBW'(DATA_WIDTH);

    spi_state_t            r_state;
    spi_state_t            w_state_next;
    spi_mode_t             r_mode;
    logic [NBW-1:0]        r_nbits;
    logic [NBW-1:0]        w_nbits_clamped;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [DATA_WIDTH-1:0] w_tx_aligned;
    logic [NCS-1:0]        r_cs_n;
    logic [NCS-1:0]        w_cs_dec;
    logic                  r_sck;
    logic                  r_sdo;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_accept;
    logic                  w_tick;
    logic                  w_leading;
    logic                  w_last_edge;
    logic                  w_shift_tick;
    logic                  w_sample_evt;
    logic                  w_shift_evt;

    assign w_accept        = (r_state == IDLE) && start && (nbits != '0);
    assign w_nbits_clamped = (nbits > MAX_NB) ? MAX_NB : nbits;
    // Left-justify so the first bit to send always sits in the MSB.
    assign w_tx_aligned    = tx_data << (MAX_NB - w_nbits_clamped);

    // Sampling edges are leading for CPHA=0 and trailing for CPHA=1.
    assign w_shift_tick = (r_state == SHIFT) && w_tick;
    assign w_sample_evt = w_shift_tick && (w_leading ^ r_mode.cpha);
    assign w_shift_evt  = w_shift_tick && !(w_leading ^ r_mode.cpha) && !w_last_edge;

    for (genvar gi = 0; gi < NCS; gi++) begin : g_cs_dec
        assign w_cs_dec[gi] = (cs_sel == CSW'(gi));
    end

    spi_sck_gen #(
        .DIV_WIDTH (DIV_WIDTH),
        .NBW       (NBW)
    ) u_sck_gen (
        .clk         (clk),
        .nrst        (nrst),
        .i_load      (w_accept),
        .i_clk_div   (clk_div),
        .i_nbits     (r_nbits),
        .i_en        ((r_state == LEAD) || (r_state == SHIFT) || (r_state == TRAIL)),
        .i_shift     (r_state == SHIFT),
        .o_tick      (w_tick),
        .o_leading   (w_leading),
        .o_last_edge (w_last_edge)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = LEAD;
            LEAD:    if (w_tick) w_state_next = SHIFT;
            SHIFT:   if (w_tick && w_last_edge) w_state_next = TRAIL;
            TRAIL:   if (w_tick) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_mode    <= '0;
            r_nbits   <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_sck     <= 1'b0;
            r_sdo     <= 1'b0;
            r_cs_n    <= '1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == TRAIL) && w_tick;
            if (w_accept) begin
                r_mode  <= {cpol, cpha};
                r_nbits <= w_nbits_clamped;
                r_rx    <= '0;
                r_sck   <= cpol;
                r_cs_n  <= ~w_cs_dec;
                r_busy  <= 1'b1;
                // CPHA=0 presents the first bit before the first SCK edge.
                if (!cpha) begin
                    r_sdo <= w_tx_aligned[DATA_WIDTH-1];
                    r_tx  <= w_tx_aligned << 1;
                end else begin
                    r_tx  <= w_tx_aligned;
                end
            end else begin
                if (r_state == IDLE) r_sck <= r_mode.cpol;
                if (w_shift_tick) r_sck <= ~r_sck;
                if (w_shift_evt) begin
                    r_sdo <= r_tx[DATA_WIDTH-1];
                    r_tx  <= r_tx << 1;
                end
                if (w_sample_evt) r_rx <= {r_rx[DATA_WIDTH-2:0], sdi};
                if ((r_state == TRAIL) && w_tick) begin
                    r_cs_n    <= '1;
                    r_busy    <= 1'b0;
                    r_rx_data <= r_rx;
                end
            end
        end
    end

    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sck     = r_sck;
    assign sdo     = r_sdo;
    assign cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi: directed scenarios plus random
// transfers checked against a behavioural SPI slave and timing formulas.
module tb_spi_master_multi;
    import spi_pkg::*;

    localparam int DW   = 32;
    localparam int NCS  = 3;
    localparam int DIVW = 8;
    localparam int CSW  = 2;
    localparam int NBW  = 6;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            start = 1'b0;
    logic [CSW-1:0]  cs_sel = '0;
    logic            cpol = 1'b0;
    logic            cpha = 1'b0;
    logic [NBW-1:0]  nbits = '0;
    logic [DIVW-1:0] clk_div = '0;
    logic [DW-1:0]   tx_data = '0;
    logic [DW-1:0]   rx_data;
    logic            busy;
    logic            done;
    logic            sck;
    logic            sdo;
    logic            sdi;
    logic [NCS-1:0]  cs_n;

    int total = 0;
    int bad   = 0;

    // Behavioural slave: shifts its word out MSB first, captures sdo.
    bit          loop_en = 1'b0;
    bit          slv_active = 1'b0;
    bit          s_cpol = 1'b0;
    bit          s_cpha = 1'b0;
    logic        slv_sdi = 1'b0;
    bit          slv_q[$];
    logic [DW-1:0] slv_rx = '0;

    assign sdi = loop_en ? sdo : slv_sdi;

    always #5 clk = ~clk;

    spi_master_multi #(
        .DATA_WIDTH (DW),
        .NCS        (NCS),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .cs_sel  (cs_sel),
        .cpol    (cpol),
        .cpha    (cpha),
        .nbits   (nbits),
        .clk_div (clk_div),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .sck     (sck),
        .sdo     (sdo),
        .sdi     (sdi),
        .cs_n    (cs_n)
    );

    always @(sck) begin
        if (slv_active) begin
            if ((sck != s_cpol) ^ s_cpha) begin
                slv_rx = {slv_rx[DW-2:0], sdo};
            end else if (slv_q.size() > 0) begin
                slv_sdi = slv_q.pop_front();
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic xfer(input string tag, input int sel, input bit pol, input bit pha,
                        input int nb, input int div, input logic [DW-1:0] txw,
                        input logic [DW-1:0] slvw, input bit loop);
        int n, h, c, edges, spacing_bad, cs_low, other_low, busy_bad, done_c;
        logic prev_sck;
        logic [63:0] mask;
        n    = (nb > DW) ? DW : nb;
        h    = div + 1;
        mask = (64'd1 << n) - 64'd1;
        cs_sel  = CSW'(sel);
        cpol    = pol;
        cpha    = pha;
        nbits   = NBW'(nb);
        clk_div = DIVW'(div);
        tx_data = txw;
        loop_en = loop;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_cpol = pol;
        s_cpha = pha;
        slv_q.delete();
        for (int i = n - 1; i >= 0; i--) slv_q.push_back(slvw[i]);
        slv_rx = '0;
        if (!pha) slv_sdi = slv_q.pop_front();
        slv_active = 1'b1;

        c = 0; edges = 0; spacing_bad = 0; cs_low = 0; other_low = 0; busy_bad = 0;
        done_c = -1;
        prev_sck = sck;
        while (done_c < 0 && c < 20000) begin
            if (done === 1'b1) done_c = c;
            if (sel < NCS && cs_n[sel] === 1'b0) cs_low++;
            for (int i = 0; i < NCS; i++) begin
                if (i != sel && cs_n[i] !== 1'b1) other_low++;
            end
            if (busy !== ((done_c < 0) ? 1'b1 : 1'b0)) busy_bad++;
            if (sck !== prev_sck) begin
                edges++;
                if (c != (edges + 1) * h) spacing_bad++;
                prev_sck = sck;
            end
            if (done_c < 0) begin
                @(posedge clk); #1;
                c++;
            end
        end
        slv_active = 1'b0;

        check({tag, " done_cycle"}, 64'(done_c), 64'((2 * n + 2) * h));
        check({tag, " sck_edges"}, 64'(edges), 64'(2 * n));
        check({tag, " edge_timing"}, 64'(spacing_bad), 64'd0);
        check({tag, " cs_low_cycles"}, 64'(cs_low), (sel < NCS) ? 64'((2 * n + 2) * h) : 64'd0);
        check({tag, " other_cs"}, 64'(other_low), 64'd0);
        check({tag, " busy"}, 64'(busy_bad), 64'd0);
        check({tag, " cs_at_done"}, 64'(cs_n), 64'({NCS{1'b1}}));
        check({tag, " rx_data"}, 64'(rx_data), (loop ? 64'(txw) : 64'(slvw)) & mask);
        if (!loop) check({tag, " slave_rx"}, 64'(slv_rx), 64'(txw) & mask);
        @(posedge clk); #1;
        check({tag, " sck_idle"}, 64'(sck), 64'(pol));
        $display("xfer %s: sel=%0d mode=%0d nbits=%0d div=%0d tx=%h rx=%h done_at=%0d",
                 tag, sel, {pol, pha}, nb, div, txw, rx_data, done_c);
    endtask

    initial begin
        int c, g, nd, edges, anomalies;
        logic psck;

        repeat (3) @(posedge clk);
        #1;
        check("reset sck", 64'(sck), 64'd0);
        check("reset sdo", 64'(sdo), 64'd0);
        check("reset cs_n", 64'(cs_n), 64'({NCS{1'b1}}));
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset rx_data", 64'(rx_data), 64'd0);
        nrst = 1'b1;
        @(posedge clk); #1;

        xfer("mode0_loop", 0, SPI_MODE0.cpol, SPI_MODE0.cpha, 8, 0, 32'h0000_00A5, '0, 1'b1);
        xfer("mode3_cs1", 1, SPI_MODE3.cpol, SPI_MODE3.cpha, 24, 2, $urandom(), 32'h0012_3456, 1'b0);
        xfer("mode1_32", 0, SPI_MODE1.cpol, SPI_MODE1.cpha, 32, 1, 32'hDEAD_BEEF, $urandom(), 1'b0);
        xfer("mode2_32", 2, SPI_MODE2.cpol, SPI_MODE2.cpha, 32, 0, 32'hDEAD_BEEF, $urandom(), 1'b0);
        xfer("nbits40", 1, 1'b0, 1'b1, 40, 0, $urandom(), $urandom(), 1'b0);
        xfer("cs_sel3", 3, 1'b0, 1'b0, 12, 1, $urandom(), $urandom(), 1'b0);
        xfer("nbits1", 0, 1'b1, 1'b0, 1, 3, 32'h1, 32'h1, 1'b0);

        // nbits=0 start must be ignored entirely
        cs_sel = '0; nbits = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        anomalies = 0;
        repeat (8) begin
            if (busy !== 1'b0 || done !== 1'b0 || cs_n !== {NCS{1'b1}}) anomalies++;
            @(posedge clk); #1;
        end
        check("nbits0 ignored", 64'(anomalies), 64'd0);
        $display("xfer nbits0: anomalies=%0d", anomalies);

        // start held high: back-to-back transfers with a 2-cycle CS gap
        cs_sel = '0; cpol = 1'b0; cpha = 1'b0; nbits = NBW'(4); clk_div = DIVW'(1);
        tx_data = 32'h9; loop_en = 1'b1; start = 1'b1;
        wait_done(500, c);
        check("held first_done", 64'(c), 64'd21);
        g = 0;
        while (cs_n[0] === 1'b1 && g < 50) begin
            g++;
            @(posedge clk); #1;
        end
        check("held cs_gap", 64'(g), 64'd2);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1; start = 1'b1;
        repeat (4) @(posedge clk);
        #1; start = 1'b0;
        nd = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        check("held single_done", 64'(nd), 64'd1);
        check("held rx_data", 64'(rx_data), 64'h9);
        $display("xfer held: first_done=%0d gap=%0d extra_window_dones=%0d", c, g, nd);

        // reset in the middle of a mode 0 transfer
        cs_sel = '0; cpol = 1'b0; cpha = 1'b0; nbits = NBW'(16); clk_div = DIVW'(1);
        tx_data = 32'h0000_C3A5; loop_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        psck = sck; edges = 0; c = 0;
        while (edges < 10 && c < 500) begin
            @(posedge clk); #1;
            c++;
            if (sck !== psck) begin
                edges++;
                psck = sck;
            end
        end
        check("rst edge10 reached", 64'(edges), 64'd10);
        nrst = 1'b0;
        @(posedge clk); #1;
        check("rst cs_n", 64'(cs_n), 64'({NCS{1'b1}}));
        check("rst sck", 64'(sck), 64'd0);
        check("rst rx_data", 64'(rx_data), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        nrst = 1'b1;
        nd = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        check("rst no_done", 64'(nd), 64'd0);
        $display("xfer midreset: edges=%0d", edges);
        xfer("post_reset", 0, 1'b0, 1'b0, 16, 1, 32'h0000_C3A5, '0, 1'b1);

        for (int t = 0; t < 12; t++) begin
            xfer($sformatf("rnd%0d", t), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(1, 36)), int'($urandom_range(0, 3)),
                 $urandom(), $urandom(), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
